// File: rtl/hilo_reg_file_if.sv
// HI/LO write-side bus between the pipeline/divider (master) and the HI/LO register file (slave).
interface hilo_reg_file_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  read_hilo_req;
  logic                  ex_write_hilo_en;
  logic [DATA_WIDTH-1:0] ex_hi_data;
  logic [DATA_WIDTH-1:0] ex_lo_data;
  logic                  mem_write_hilo_en;
  logic [DATA_WIDTH-1:0] mem_hi_data;
  logic [DATA_WIDTH-1:0] mem_lo_data;
  logic                  wb_write_hilo_en;
  logic [DATA_WIDTH-1:0] wb_hi_data;
  logic [DATA_WIDTH-1:0] wb_lo_data;
  logic                  div_valid;
  logic [DATA_WIDTH-1:0] div_hi;
  logic [DATA_WIDTH-1:0] div_lo;
  logic                  div_ready;
  logic [DATA_WIDTH-1:0] hi_val_mux_data;
  logic [DATA_WIDTH-1:0] lo_val_mux_data;
  logic                  hilo_stall;

  modport master (
    output read_hilo_req,
    output ex_write_hilo_en, ex_hi_data, ex_lo_data,
    output mem_write_hilo_en, mem_hi_data, mem_lo_data,
    output wb_write_hilo_en, wb_hi_data, wb_lo_data,
    output div_valid, div_hi, div_lo,
    input  div_ready,
    input  hi_val_mux_data, lo_val_mux_data,
    input  hilo_stall
  );

  modport slave (
    input  read_hilo_req,
    input  ex_write_hilo_en, ex_hi_data, ex_lo_data,
    input  mem_write_hilo_en, mem_hi_data, mem_lo_data,
    input  wb_write_hilo_en, wb_hi_data, wb_lo_data,
    input  div_valid, div_hi, div_lo,
    output div_ready,
    output hi_val_mux_data, lo_val_mux_data,
    output hilo_stall
  );
endinterface

// File: rtl/hilo_reg_file.sv
// Architectural HI/LO register pair with divider skid buffer and EX read path.
// Optional feature macro HILO_FORWARD_EN: forward EX/MEM/WB writes instead of stalling the reader.
module hilo_reg_file #(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input logic            clk,
  input logic            rst,
  hilo_reg_file_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]            state;
  logic [0:0]            state_nx;
  logic [DATA_WIDTH-1:0] hi_reg;
  logic [DATA_WIDTH-1:0] lo_reg;
  logic [DATA_WIDTH-1:0] hi_nx;
  logic [DATA_WIDTH-1:0] lo_nx;
  logic [DATA_WIDTH-1:0] sk_hi;
  logic [DATA_WIDTH-1:0] sk_lo;
  logic [DATA_WIDTH-1:0] sk_hi_nx;
  logic [DATA_WIDTH-1:0] sk_lo_nx;
  logic [DATA_WIDTH-1:0] hi_mux;
  logic [DATA_WIDTH-1:0] lo_mux;
  logic                  div_accept;

  // Ready only in IDLE; held low for the whole reset assertion.
  assign bus.div_ready = rst & (state == IDLE);
  assign div_accept    = bus.div_valid & bus.div_ready;

  // State, architectural registers and skid buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      hi_reg <= RESET_VALUE;
      lo_reg <= RESET_VALUE;
      sk_hi  <= '0;
      sk_lo  <= '0;
    end else begin
      state  <= state_nx;
      hi_reg <= hi_nx;
      lo_reg <= lo_nx;
      sk_hi  <= sk_hi_nx;
      sk_lo  <= sk_lo_nx;
    end
  end

  // Next state: a WB write always takes the register; the divider result waits in the skid behind it.
  always_comb begin
    state_nx = state;
    hi_nx    = hi_reg;
    lo_nx    = lo_reg;
    sk_hi_nx = sk_hi;
    sk_lo_nx = sk_lo;
    case (state)
      IDLE: begin
        if (bus.wb_write_hilo_en) begin
          hi_nx = bus.wb_hi_data;
          lo_nx = bus.wb_lo_data;
        end
        if (div_accept) begin
          if (bus.wb_write_hilo_en) begin
            sk_hi_nx = bus.div_hi;
            sk_lo_nx = bus.div_lo;
            state_nx = HOLD;
          end else begin
            hi_nx = bus.div_hi;
            lo_nx = bus.div_lo;
          end
        end
      end
      HOLD: begin
        if (bus.wb_write_hilo_en) begin
          hi_nx = bus.wb_hi_data;
          lo_nx = bus.wb_lo_data;
        end else begin
          hi_nx    = sk_hi;
          lo_nx    = sk_lo;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef HILO_FORWARD_EN
  // Youngest in-flight write wins; HI and LO always travel together.
  always_comb begin
    hi_mux = hi_reg;
    lo_mux = lo_reg;
    if (bus.ex_write_hilo_en) begin
      hi_mux = bus.ex_hi_data;
      lo_mux = bus.ex_lo_data;
    end else if (bus.mem_write_hilo_en) begin
      hi_mux = bus.mem_hi_data;
      lo_mux = bus.mem_lo_data;
    end else if (bus.wb_write_hilo_en) begin
      hi_mux = bus.wb_hi_data;
      lo_mux = bus.wb_lo_data;
    end else if (state == HOLD) begin
      hi_mux = sk_hi;
      lo_mux = sk_lo;
    end
  end

  assign bus.hilo_stall = 1'b0;

  logic unused_inputs;
  assign unused_inputs = &{1'b0, bus.read_hilo_req};
`else
  // No forwarding: the reader sees the skid or the registers and waits out younger writes.
  always_comb begin
    hi_mux = hi_reg;
    lo_mux = lo_reg;
    if (state == HOLD) begin
      hi_mux = sk_hi;
      lo_mux = sk_lo;
    end
  end

  // The EX write belongs to the reading instruction itself, so it never causes a stall.
  assign bus.hilo_stall = rst & bus.read_hilo_req &
                          (bus.mem_write_hilo_en | bus.wb_write_hilo_en | (state == HOLD));

  logic unused_inputs;
  assign unused_inputs = &{1'b0, bus.ex_write_hilo_en, bus.ex_hi_data, bus.ex_lo_data};
`endif

  assign bus.hi_val_mux_data = hi_mux;
  assign bus.lo_val_mux_data = lo_mux;

  // Divider must hold a refused result stable until it is taken.
  a_div_hold: assert property (@(posedge clk) disable iff (!rst)
    (bus.div_valid && !bus.div_ready) |=> (bus.div_valid && $stable({bus.div_hi, bus.div_lo})));

endmodule

// File: tb/tb_hilo_reg_file.sv
// Scoreboard bench for hilo_reg_file: stimulus pushes expected outputs, a negedge monitor compares them.
module tb_hilo_reg_file;
  localparam int unsigned    DW = 32;
  localparam logic [DW-1:0]  RV = 32'hDEAD_0001;

  typedef struct {
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
    logic          rdy;
    logic          stall;
  } exp_t;

  logic clk;
  logic rst;
  hilo_reg_file_if #(.DATA_WIDTH(DW)) bus ();

  hilo_reg_file #(.DATA_WIDTH(DW), .RESET_VALUE(RV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t            sb[$];
  logic [2*DW-1:0] pend[$];   // divider results accepted but not yet architectural
  logic [DW-1:0]   m_hi;
  logic [DW-1:0]   m_lo;
  int              passed = 0;
  int              total  = 0;

  logic          d_rst, d_req, d_ex, d_mem, d_wb, d_dv;
  logic [DW-1:0] d_exh, d_exl, d_memh, d_meml, d_wbh, d_wbl, d_dh, d_dl;

  function automatic void chk(string name, logic [DW-1:0] act, logic [DW-1:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
  endfunction

  task automatic idle();
    d_req = 0; d_ex = 0; d_mem = 0; d_wb = 0;
    d_exh = '0; d_exl = '0; d_memh = '0; d_meml = '0; d_wbh = '0; d_wbl = '0;
  endtask

  // One cycle: drive, predict this cycle's outputs, then apply the edge to the model.
  task automatic step();
    exp_t e;
    logic acc;
    @(posedge clk);
    #1;
    rst                   = d_rst;
    bus.read_hilo_req     = d_req;
    bus.ex_write_hilo_en  = d_ex;  bus.ex_hi_data  = d_exh;  bus.ex_lo_data  = d_exl;
    bus.mem_write_hilo_en = d_mem; bus.mem_hi_data = d_memh; bus.mem_lo_data = d_meml;
    bus.wb_write_hilo_en  = d_wb;  bus.wb_hi_data  = d_wbh;  bus.wb_lo_data  = d_wbl;
    bus.div_valid         = d_dv;  bus.div_hi      = d_dh;   bus.div_lo      = d_dl;
    if (!d_rst) begin
      m_hi = RV; m_lo = RV; pend.delete();
    end
    e.rdy = d_rst && (pend.size() == 0);
    {e.hi, e.lo} = (pend.size() != 0) ? pend[0] : {m_hi, m_lo};
`ifdef HILO_FORWARD_EN
    e.stall = 1'b0;
    if (d_ex)       {e.hi, e.lo} = {d_exh, d_exl};
    else if (d_mem) {e.hi, e.lo} = {d_memh, d_meml};
    else if (d_wb)  {e.hi, e.lo} = {d_wbh, d_wbl};
`else
    e.stall = d_rst && d_req && (d_mem || d_wb || (pend.size() != 0));
`endif
    sb.push_back(e);
    acc = d_dv && e.rdy;
    if (d_rst) begin
      if (pend.size() != 0 && !d_wb) {m_hi, m_lo} = pend.pop_front();
      if (d_wb) {m_hi, m_lo} = {d_wbh, d_wbl};
      if (acc) begin
        if (d_wb) pend.push_back({d_dh, d_dl});
        else      {m_hi, m_lo} = {d_dh, d_dl};
      end
    end
    if (acc) d_dv = 0;
  endtask

  function automatic logic [DW-1:0] rnd_word();
    return ($urandom_range(0, 1) == 0) ? DW'($urandom_range(0, 15)) : DW'($urandom);
  endfunction

  // Monitor: outputs are presented every cycle; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("hi_val_mux_data", bus.hi_val_mux_data, e.hi);
        chk("lo_val_mux_data", bus.lo_val_mux_data, e.lo);
        chk("div_ready", DW'(bus.div_ready), DW'(e.rdy));
        chk("hilo_stall", DW'(bus.hilo_stall), DW'(e.stall));
      end
    end
  end

  initial begin
    rst = 0;
    bus.read_hilo_req = 0; bus.ex_write_hilo_en = 0; bus.mem_write_hilo_en = 0;
    bus.wb_write_hilo_en = 0; bus.div_valid = 0;
    bus.ex_hi_data = '0; bus.ex_lo_data = '0; bus.mem_hi_data = '0; bus.mem_lo_data = '0;
    bus.wb_hi_data = '0; bus.wb_lo_data = '0; bus.div_hi = '0; bus.div_lo = '0;
    m_hi = RV; m_lo = RV;
    idle(); d_rst = 0; d_dv = 0; d_dh = '0; d_dl = '0;
    repeat (2) step();
    d_rst = 1; step();

    // WB commit
    d_wb = 1; d_wbh = 32'h11; d_wbl = 32'h22; step();
    idle(); step();

    // EX over MEM over register
    d_wb = 1; d_wbh = 32'h1; d_wbl = 32'h1; step();
    idle(); step();
    d_req = 1; d_mem = 1; d_memh = 32'h5; d_meml = 32'h1;
    d_ex = 1; d_exh = 32'h9; d_exl = 32'h1; step();
    d_ex = 0; step();
    idle(); step();

    // Divider collides with WB
    d_dv = 1; d_dh = 32'hA; d_dl = 32'hB; d_wb = 1; d_wbh = 32'h3; d_wbl = 32'h4; step();
    idle(); d_req = 1; step();
    step();
    idle(); step();

    // HOLD held by three back-to-back WB writes
    d_dv = 1; d_dh = 32'hC0; d_dl = 32'hC1; d_wb = 1; d_wbh = 32'h50; d_wbl = 32'h51; step();
    for (int i = 0; i < 3; i++) begin
      d_wb = 1; d_wbh = 32'h100 + DW'(i); d_wbl = 32'h200 + DW'(i); d_req = 1; step();
    end
    idle(); step();
    step();

    // Reset asserted mid-HOLD discards the skid
    d_dv = 1; d_dh = 32'hEE; d_dl = 32'hEF; d_wb = 1; d_wbh = 32'h7; d_wbl = 32'h8; step();
    idle(); d_dv = 0; d_rst = 0; step();
    step();
    d_rst = 1; step();
    step();

    // Reader against an in-flight MEM write, then its WB, then committed
    d_req = 1; d_mem = 1; d_memh = 32'h33; d_meml = 32'h44; step();
    d_mem = 0; d_wb = 1; d_wbh = 32'h33; d_wbl = 32'h44; step();
    d_wb = 0; step();
    idle(); step();

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      d_rst  = ($urandom_range(0, 79) != 0);
      d_req  = 1'($urandom_range(0, 1));
      d_ex   = ($urandom_range(0, 4) == 0); d_exh  = rnd_word(); d_exl  = rnd_word();
      d_mem  = ($urandom_range(0, 3) == 0); d_memh = rnd_word(); d_meml = rnd_word();
      d_wb   = ($urandom_range(0, 2) == 0); d_wbh  = rnd_word(); d_wbl  = rnd_word();
      if (!d_rst) d_dv = 0;
      else if (!d_dv && $urandom_range(0, 2) == 0) begin
        d_dv = 1; d_dh = rnd_word(); d_dl = rnd_word();
      end
      step();
    end
    idle(); d_dv = 0; step();

    repeat (3) @(negedge clk);
    total++;
    if (sb.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
